// File: rtl/memory_stage.sv
// y86-64 memory stage: M pipeline register plus byte-addressed little-endian
// data memory performing the 8-byte load/store selected by M_icode.
module memory_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        W_exc,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  // Highest legal start address of an 8-byte access; no wrap-around.
  localparam logic [63:0] LAST_OK = 64'(DEPTH - 8);

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam m_reg_t BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  m_reg_t m_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q <= BUBBLE;
    end else if (M_bubble) begin
      m_q <= BUBBLE;
    end else if (!M_stall) begin
      m_q <= '{
        stat:  e_stat,
        icode: e_icode,
        cnd:   e_Cnd,
        val_e: e_valE,
        val_a: e_valA,
        dst_e: e_dstE,
        dst_m: e_dstM
      };
    end
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_addr;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = 64'd0;
    unique case (m_q.icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: begin
        mem_wr   = 1'b1;
        mem_addr = m_q.val_e;
      end
      I_MRMOVQ: begin
        mem_rd   = 1'b1;
        mem_addr = m_q.val_e;
      end
      I_POPQ, I_RET: begin
        mem_rd   = 1'b1;
        mem_addr = m_q.val_a;
      end
      default: ;
    endcase
  end

  logic          dmem_error;
  logic [AW-1:0] base;
  logic          store_en;

  assign dmem_error = (mem_rd || mem_wr) && (mem_addr > LAST_OK);
  assign base       = mem_addr[AW-1:0];
  assign store_en   = mem_wr && !dmem_error && (m_q.stat == STAT_AOK)
                      && !W_exc && reset;

  // NOTE: the data memory has no reset; contents start at zero and survive
  // reset, which lets it map onto plain RAM.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  always_ff @(posedge clock) begin
    if (store_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= m_q.val_a[8*i +: 8];
      end
    end
  end

  // Reads see pre-edge contents, so a same-cycle store is not forwarded.
  always_comb begin
    m_valM = 64'd0;
    if (mem_rd && !dmem_error) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = mem[base + AW'(i)];
      end
    end
  end

  assign m_stat = dmem_error ? STAT_ADR : m_q.stat;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the y86-64 pipeline.
- Holds the M pipeline register, which latches execute results, and contains a byte-addressed little-endian data memory.
- Performs the 8-byte load or store selected by M_icode and produces m_valM and m_stat.
- Drives forwarding and misprediction signals back to decode and fetch, and feeds the writeback register.

Parameters:
- DEPTH, 1024, data memory size in bytes (multiple of 8, >= 8).
- AW, 10, address bits used internally (clog2 of DEPTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- M_stall  input  1  hold the M register
- M_bubble  input  1  load a bubble into the M register
- e_stat  input  3  status from execute
- e_icode  input  4  instruction code from execute
- e_Cnd  input  1  condition result from execute
- e_valE  input  64  ALU result
- e_valA  input  64  store data / pop and ret address
- e_dstE  input  4  destination register for valE
- e_dstM  input  4  destination register for valM
- W_exc  input  1  writeback stage holds a non-AOK status; blocks stores
- M_stat  output  3  registered status
- M_icode  output  4  registered instruction code
- M_Cnd  output  1  registered condition
- M_valE  output  64  registered ALU result
- M_valA  output  64  registered valA, used for the mispredict path
- M_dstE  output  4  registered dstE
- M_dstM  output  4  registered dstM
- m_valM  output  64  load data (combinational)
- m_stat  output  3  stage status after the memory check (combinational)

Behaviour:
- Encodings:
  - icode: HALT 0, NOP 1, RMMOVQ 4, MRMOVQ 5, CALL 8, RET 9, PUSHQ A, POPQ B.
  - stat: AOK 1, HLT 2, ADR 3, INS 4.
  - RNONE = 4'hF.
- M register update priority: reset > bubble > stall > load.
  - reset low (asynchronous): register takes the bubble value immediately. The bubble value is stat=AOK, icode=NOP, Cnd=0, valE=0, valA=0, dstE=RNONE, dstM=RNONE.
  - Rising edge with M_bubble=1: register takes the bubble value, even if M_stall=1.
  - Rising edge with M_stall=1 and M_bubble=0: register holds.
  - Otherwise: register captures all e_* inputs. Latency from e_* to M_* is one cycle.
- Address select:
  - mem_addr = M_valA for RET and POPQ.
  - mem_addr = M_valE for RMMOVQ, PUSHQ, CALL, MRMOVQ.
  - Otherwise mem_addr = 0 and no access.
- Read (MRMOVQ, POPQ, RET):
  - m_valM = bytes [mem_addr .. mem_addr+7], little-endian, combinational.
  - m_valM = 0 when not reading or on a memory error.
- Write (RMMOVQ, PUSHQ, CALL):
  - M_valA is written to bytes [mem_addr .. mem_addr+7] at the rising edge.
  - The write is suppressed if any of these hold: dmem_error=1, M_stat != AOK, W_exc=1, or reset low.
  - M_stall does not suppress the write. The controller must not stall M on a store.
- Memory error:
  - dmem_error = access AND (mem_addr > DEPTH-8), using the full 64-bit compare. There is no wrap-around, so address 2^64-1 is an error.
  - Unaligned accesses are legal.
- Status: m_stat = ADR if dmem_error, else M_stat.
- Memory contents are zero at time zero and are not cleared by reset. A reset mid-store cancels the store for that edge.
- Read-after-write to the same address in consecutive cycles returns the new data. A read in the same cycle as a write sees the old contents.

Test Plan:
- Reset low mid-run → all M_* outputs take bubble values asynchronously, with no clock edge. Afterwards m_stat=1 and m_valM=0.
- RMMOVQ with e_valE=0x10, e_valA=0x1122334455667788, then MRMOVQ with e_valE=0x10 → m_valM=0x1122334455667788. Byte 0x10 holds 0x88.
- PUSHQ at valE=0x3F8 (DEPTH=1024) → write succeeds. MRMOVQ at 0x3F9 → m_stat=3, m_valM=0. RET with valA=0xFFFFFFFFFFFFFFFF → m_stat=3.
- M_stall=1 for 3 cycles while e_* changes → M_* stays constant. M_stall=1 together with M_bubble=1 → bubble values loaded.
- RMMOVQ with W_exc=1, or with e_stat=HLT → memory unchanged. A subsequent read returns the prior value and m_stat equals the registered stat.
- POPQ with e_valA=0x20, e_valE=0x28, e_dstE=4, e_dstM=0 → M_dstE=4, M_dstM=0, M_valE=0x28. m_valM = memory at 0x20.
